// File: rtl/reg_file_sb.sv
// 32x32 register file with write-back bypass and a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              RW,
    input  logic [ADDR_W-1:0] DA,
    input  logic [DATA_W-1:0] BUS_D,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    output logic [DATA_W-1:0] A_DATA,
    output logic [DATA_W-1:0] B_DATA,
    input  logic              ISSUE_VALID,
    input  logic              USE_A,
    input  logic              USE_B,
    input  logic              ISSUE_RW,
    input  logic [ADDR_W-1:0] ISSUE_DA,
    output logic              STALL,
    output logic              SB_ERR
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0][CNT_W-1:0]  cnt;
    logic [NREG-1:0]             inc, dec;
    logic                        wr_en, haz_a, haz_b, full_d, err_set;

    assign wr_en = RW && (DA != '0);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[DA] <= BUS_D;
        end
    end

    always_comb begin
        A_DATA = (AA == '0) ? '0 : regs[AA];
        B_DATA = (BA == '0) ? '0 : regs[BA];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (DA == AA)) A_DATA = BUS_D;
        if (wr_en && (DA == BA)) B_DATA = BUS_D;
`endif
    end

    // A last in-flight write landing this cycle is covered by the bypass.
    always_comb begin
        haz_a  = USE_A && (AA != '0) && (cnt[AA] != '0);
        haz_b  = USE_B && (BA != '0) && (cnt[BA] != '0);
`ifdef REGFILE_BYPASS_EN
        if ((cnt[AA] == CNT_W'(1)) && wr_en && (DA == AA)) haz_a = 1'b0;
        if ((cnt[BA] == CNT_W'(1)) && wr_en && (DA == BA)) haz_b = 1'b0;
`endif
        full_d = ISSUE_RW && (ISSUE_DA != '0) && (cnt[ISSUE_DA] == CNT_MAX);
        STALL  = ISSUE_VALID && (haz_a || haz_b || full_d);
    end

    // Register 0 is excluded from the scoreboard entirely.
    always_comb begin
        inc = '0;
        dec = '0;
        if (ISSUE_VALID && ISSUE_RW && !STALL && (ISSUE_DA != '0)) inc[ISSUE_DA] = 1'b1;
        if (wr_en) dec[DA] = 1'b1;
        err_set = wr_en && (cnt[DA] == '0);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt    <= '0;
            SB_ERR <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (dec[r] && !inc[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
            if (err_set) SB_ERR <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a spec-level model checked every cycle plus hand-computed checks.
module tb_reg_file_sb;
    logic        CLOCK = 1'b0;
    logic        RESET, RW, ISSUE_VALID, USE_A, USE_B, ISSUE_RW;
    logic [4:0]  DA, AA, BA, ISSUE_DA;
    logic [31:0] BUS_D, A_DATA, B_DATA;
    logic        STALL, SB_ERR;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_err;

    reg_file_sb dut (
        .CLOCK(CLOCK), .RESET(RESET), .RW(RW), .DA(DA), .BUS_D(BUS_D),
        .AA(AA), .BA(BA), .A_DATA(A_DATA), .B_DATA(B_DATA),
        .ISSUE_VALID(ISSUE_VALID), .USE_A(USE_A), .USE_B(USE_B),
        .ISSUE_RW(ISSUE_RW), .ISSUE_DA(ISSUE_DA), .STALL(STALL), .SB_ERR(SB_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (RW && DA == a) return BUS_D;
`endif
        return m_reg[a];
    endfunction

    function automatic bit m_haz(input logic use_r, input logic [4:0] a);
        if (!use_r || a == 0 || m_cnt[a] == 0) return 0;
`ifdef REGFILE_BYPASS_EN
        if (m_cnt[a] == 1 && RW && DA == a) return 0;
`endif
        return 1;
    endfunction

    function automatic bit m_stall();
        bit full;
        full = ISSUE_RW && ISSUE_DA != 0 && m_cnt[ISSUE_DA] == 3;
        return ISSUE_VALID && (m_haz(USE_A, AA) || m_haz(USE_B, BA) || full);
    endfunction

    always @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 0;
                m_cnt[i] = 0;
            end
            m_err = 0;
            armed = 1;
        end else if (armed) begin
            bit inc, dec;
            inc = ISSUE_VALID && ISSUE_RW && !m_stall() && ISSUE_DA != 0;
            dec = RW && DA != 0;
            if (dec && m_cnt[DA] == 0) m_err = 1;
            if (dec) m_reg[DA] = BUS_D;
            if (!(inc && dec && ISSUE_DA == DA)) begin
                if (inc) m_cnt[ISSUE_DA]++;
                if (dec && m_cnt[DA] > 0) m_cnt[DA]--;
            end
        end
    end

    always @(negedge CLOCK) begin
        if (armed) begin
            chk("model_a_data", A_DATA, m_read(AA));
            chk("model_b_data", B_DATA, m_read(BA));
            chk("model_stall", {31'b0, STALL}, {31'b0, m_stall()});
            chk("model_sb_err", {31'b0, SB_ERR}, {31'b0, m_err});
        end
    end

    task automatic idle();
        RESET = 0; RW = 0; DA = 0; BUS_D = 0; AA = 0; BA = 0;
        ISSUE_VALID = 0; USE_A = 0; USE_B = 0; ISSUE_RW = 0; ISSUE_DA = 0;
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic issue_wr(input logic [4:0] d);
        ISSUE_VALID = 1; ISSUE_RW = 1; ISSUE_DA = d;
    endtask

    initial begin
        idle();
        RESET = 1;
        tick();
        // reset state
        idle(); AA = 5; BA = 9; #2;
        chk("rst_a_data", A_DATA, 32'h0);
        chk("rst_b_data", B_DATA, 32'h0);
        chk("rst_stall", {31'b0, STALL}, 32'h0);
        chk("rst_sb_err", {31'b0, SB_ERR}, 32'h0);

        // write then read
        issue_wr(5); tick(); idle();
        RW = 1; DA = 5; BUS_D = 32'hDEADBEEF; tick(); idle();
        AA = 5; #2;
        chk("wr_rd_a", A_DATA, 32'hDEADBEEF);
        chk("wr_rd_err", {31'b0, SB_ERR}, 32'h0);

        // register 0
        RW = 1; DA = 0; BUS_D = 32'hFFFFFFFF; AA = 0; BA = 0; #2;
        chk("r0_same_cycle", A_DATA, 32'h0);
        tick(); idle(); #2;
        chk("r0_read", A_DATA, 32'h0);
        for (int i = 0; i < 4; i++) begin
            issue_wr(0); USE_A = 1; AA = 0; #2;
            chk("r0_issue_stall", {31'b0, STALL}, 32'h0);
            tick();
        end
        idle(); #2;
        chk("r0_no_err", {31'b0, SB_ERR}, 32'h0);

        // RAW stall and release
        issue_wr(7); tick(); idle();
        ISSUE_VALID = 1; USE_A = 1; AA = 7; #2;
        chk("raw_stall", {31'b0, STALL}, 32'h1);
        tick(); #2;
        chk("raw_stall_hold", {31'b0, STALL}, 32'h1);
        RW = 1; DA = 7; BUS_D = 32'h12; #2;
`ifdef REGFILE_BYPASS_EN
        chk("raw_release", {31'b0, STALL}, 32'h0);
        chk("raw_bypass", A_DATA, 32'h12);
`else
        chk("raw_release", {31'b0, STALL}, 32'h1);
        chk("raw_nobypass", A_DATA, 32'h0);
`endif
        tick(); RW = 0; #2;
        chk("raw_after", {31'b0, STALL}, 32'h0);
        chk("raw_after_data", A_DATA, 32'h12);
        tick(); idle();

        // counter saturation
        for (int i = 0; i < 3; i++) begin
            issue_wr(9); #2;
            chk("sat_fill", {31'b0, STALL}, 32'h0);
            tick();
        end
        #2;
        chk("sat_full", {31'b0, STALL}, 32'h1);
        RW = 1; DA = 9; BUS_D = 32'h99; #2;
        chk("sat_full_dec", {31'b0, STALL}, 32'h1);
        tick(); RW = 0; #2;
        chk("sat_proceed", {31'b0, STALL}, 32'h0);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            RW = 1; DA = 9; BUS_D = 32'h90 + i; tick();
        end
        idle(); #2;
        chk("sat_drain_err", {31'b0, SB_ERR}, 32'h0);

        // simultaneous inc/dec
        issue_wr(3); tick();
        RW = 1; DA = 3; BUS_D = 32'h33; #2;
        chk("sim_no_stall", {31'b0, STALL}, 32'h0);
        tick(); idle();
        ISSUE_VALID = 1; USE_B = 1; BA = 3; #2;
        chk("sim_cnt_kept", {31'b0, STALL}, 32'h1);
        chk("sim_b_old", B_DATA, 32'h33);
        tick(); #2;
        chk("sim_stall_hold", {31'b0, STALL}, 32'h1);
        RW = 1; DA = 3; BUS_D = 32'h34; #2;
`ifdef REGFILE_BYPASS_EN
        chk("sim_release", {31'b0, STALL}, 32'h0);
        chk("sim_bypass", B_DATA, 32'h34);
`else
        chk("sim_release", {31'b0, STALL}, 32'h1);
        chk("sim_nobypass", B_DATA, 32'h33);
`endif
        tick(); RW = 0; #2;
        chk("sim_after", {31'b0, STALL}, 32'h0);
        chk("sim_after_data", B_DATA, 32'h34);
        chk("sim_err", {31'b0, SB_ERR}, 32'h0);
        tick(); idle();

        // underflow after reset mid-flight
        issue_wr(4); tick(); idle();
        RESET = 1; tick(); idle();
        RW = 1; DA = 4; BUS_D = 32'h44; #2;
        chk("uf_before", {31'b0, SB_ERR}, 32'h0);
        tick(); idle(); #2;
        chk("uf_set", {31'b0, SB_ERR}, 32'h1);
        tick(); tick(); #2;
        chk("uf_sticky", {31'b0, SB_ERR}, 32'h1);
        RESET = 1; tick(); idle(); #2;
        chk("uf_cleared", {31'b0, SB_ERR}, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
